// File: rtl/typing_pkg.sv
// Shared types and constants for the typing-test score/timer block.
// Holds the FSM state encoding, display codes and a BCD helper.
package typing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  localparam logic [3:0] CODE_H = 4'd10;
  localparam logic [3:0] CODE_I = 4'd11;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam bcd2_t BCD_ZERO = '{tens: 4'd0, ones: 4'd0};
  localparam bcd2_t BCD_ONE  = '{tens: 4'd0, ones: 4'd1};

  function automatic bcd2_t to_bcd2(input int unsigned v);
    bcd2_t r;
    r.tens = 4'((v / 10) % 10);
    r.ones = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up/down counter with synchronous load, saturating at 00 and 99.
// Exposes the next value so the parent can register derived outputs in the same cycle.
module bcd2_counter
  import typing_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  bcd2_t load_val,
  input  logic  inc,
  input  logic  dec,
  output bcd2_t val,
  output bcd2_t nxt
);

  always_comb begin
    nxt = val;
    if (load) begin
      nxt = load_val;
    end else if (inc && !dec) begin
      if (!(val.tens == 4'd9 && val.ones == 4'd9)) begin
        if (val.ones == 4'd9) begin
          nxt.tens = val.tens + 4'd1;
          nxt.ones = 4'd0;
        end else begin
          nxt.ones = val.ones + 4'd1;
        end
      end
    end else if (dec && !inc) begin
      if (!(val.tens == 4'd0 && val.ones == 4'd0)) begin
        if (val.ones == 4'd0) begin
          nxt.tens = val.tens - 4'd1;
          nxt.ones = 4'd9;
        end else begin
          nxt.ones = val.ones - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) val <= BCD_ZERO;
    else     val <= nxt;
  end

endmodule

// File: rtl/typing_score_timer.sv
// Typing-test controller: counts down a fixed test length while scoring key
// presses, then shows the score on a two-digit multiplexed display.
module typing_score_timer
  import typing_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned TEST_SECONDS  = 30,
  parameter int unsigned REFRESH_DIV   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_correct,
  input  logic       key_wrong,
  output logic [3:0] digit_one,
  output logic [3:0] digit_two,
  output logic       one_en,
  output logic       two_en,
  output logic       fast_clk_out,
  output logic       busy,
  output logic       done
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam bcd2_t SEC_INIT = to_bcd2(TEST_SECONDS);

  state_t        state, state_nxt;
  logic [TW-1:0] tick;
  logic [RW-1:0] refresh;
  logic          running, wrap, last;
  bcd2_t         score, score_nxt, secs, secs_nxt;

  assign running = (state == ST_RUN);
  assign wrap    = running && (tick == TW'(TICKS_PER_SEC - 1));
  // A start in the same cycle as expiry wins: the test restarts, no done.
  assign last    = wrap && (secs == BCD_ONE) && !start;

  bcd2_counter u_score (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .load_val (BCD_ZERO),
    .inc      (key_correct && running),
    .dec      (key_wrong && running),
    .val      (score),
    .nxt      (score_nxt)
  );

  bcd2_counter u_secs (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .load_val (SEC_INIT),
    .inc      (1'b0),
    .dec      (wrap),
    .val      (secs),
    .nxt      (secs_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_RUN;
      ST_RUN:    if (last)  state_nxt = ST_RESULT;
      ST_RESULT: if (start) state_nxt = ST_RUN;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      tick  <= '0;
    end else begin
      state <= state_nxt;
      if (start || !running || wrap) tick <= '0;
      else                           tick <= tick + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh      <= '0;
      fast_clk_out <= 1'b0;
    end else if (refresh == RW'(REFRESH_DIV - 1)) begin
      refresh      <= '0;
      fast_clk_out <= ~fast_clk_out;
    end else begin
      refresh <= refresh + RW'(1);
    end
  end

  // Display is registered from next-state values so changes appear one cycle after their cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_one <= CODE_H;
      digit_two <= CODE_I;
      one_en    <= 1'b1;
      two_en    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy   <= (state_nxt == ST_RUN);
      done   <= last;
      two_en <= 1'b1;
      case (state_nxt)
        ST_RUN: begin
          digit_one <= secs_nxt.tens;
          digit_two <= secs_nxt.ones;
          one_en    <= (secs_nxt.tens != 4'd0);
        end
        ST_RESULT: begin
          digit_one <= score_nxt.tens;
          digit_two <= score_nxt.ones;
          one_en    <= (score_nxt.tens != 4'd0);
        end
        default: begin
          digit_one <= CODE_H;
          digit_two <= CODE_I;
          one_en    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_typing_score_timer.sv
// Directed bench for typing_score_timer with a short test (10 ticks/s, 12 s, refresh 4).
// Expected values are hand-derived from the countdown/score rules.
module tb_typing_score_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       key_correct = 1'b0;
  logic       key_wrong = 1'b0;
  logic [3:0] digit_one, digit_two;
  logic       one_en, two_en, fast_clk_out, busy, done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  typing_score_timer #(
    .TICKS_PER_SEC (10),
    .TEST_SECONDS  (12),
    .REFRESH_DIV   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .key_correct  (key_correct),
    .key_wrong    (key_wrong),
    .digit_one    (digit_one),
    .digit_two    (digit_two),
    .one_en       (one_en),
    .two_en       (two_en),
    .fast_clk_out (fast_clk_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_disp(input string tag, input int d1, input int d2,
                            input int e1, input int e2, input int b);
    check({tag, ".d1"},   32'(digit_one), 32'(d1));
    check({tag, ".d2"},   32'(digit_two), 32'(d2));
    check({tag, ".en1"},  32'(one_en),    32'(e1));
    check({tag, ".en2"},  32'(two_en),    32'(e2));
    check({tag, ".busy"}, 32'(busy),      32'(b));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Steps until done is seen or the budget runs out; n = steps taken.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check({tag, ".done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    int n, since, toggles, dc, sec;
    logic prev;

    // Reset state
    step();
    check_disp("rst", 10, 11, 1, 1, 0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.fclk", 32'(fast_clk_out), 32'd0);
    rst = 1'b0;

    // Idle: HI displayed, refresh clock toggles every 4 cycles
    prev = fast_clk_out;
    since = 0;
    toggles = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      since++;
      if (fast_clk_out !== prev) begin
        check("fclk_period", 32'(since), 32'd4);
        since = 0;
        toggles++;
        prev = fast_clk_out;
      end
      check_disp("idle", 10, 11, 1, 1, 0);
    end
    check("fclk_toggles", 32'(toggles), 32'd5);

    // Full countdown, no keys
    dc = done_cnt;
    pulse_start();
    for (int k = 0; k < 120; k++) begin
      sec = 12 - k / 10;
      check_disp("count", sec / 10, sec % 10, (sec >= 10) ? 1 : 0, 1, 1);
      check("count.done", 32'(done), 32'd0);
      step();
    end
    check("expire.done", 32'(done), 32'd1);
    check_disp("expire", 0, 0, 0, 1, 0);
    step();
    check("expire.done_low", 32'(done), 32'd0);
    check_disp("result0", 0, 0, 0, 1, 0);
    check("expire.pulses", 32'(done_cnt - dc), 32'd1);

    // Saturate at 99, then three wrong keys
    pulse_start();
    key_correct = 1'b1;
    repeat (105) step();
    key_correct = 1'b0;
    key_wrong = 1'b1;
    repeat (3) step();
    key_wrong = 1'b0;
    wait_done("sat", n);
    check_disp("sat96", 9, 6, 1, 1, 0);

    // Wrong keys at 00 saturate, both-at-once is a no-op
    pulse_start();
    key_wrong = 1'b1;
    repeat (2) step();
    key_wrong = 1'b0;
    key_correct = 1'b1;
    step();
    key_wrong = 1'b1;
    step();
    key_correct = 1'b0;
    key_wrong = 1'b0;
    wait_done("mix", n);
    check_disp("mix01", 0, 1, 0, 1, 0);

    // Key in the cycle of the final decrement is counted
    pulse_start();
    repeat (119) step();
    key_correct = 1'b1;
    step();
    key_correct = 1'b0;
    check("lastkey.done", 32'(done), 32'd1);
    check_disp("lastkey", 0, 1, 0, 1, 0);
    // Keys in RESULT are ignored
    key_correct = 1'b1;
    step();
    key_correct = 1'b0;
    step();
    check_disp("result_ignore", 0, 1, 0, 1, 0);

    // Restart during RUN at 05 s
    pulse_start();
    key_correct = 1'b1;
    repeat (3) step();
    key_correct = 1'b0;
    repeat (69) step();
    check_disp("at05", 0, 5, 0, 1, 1);
    dc = done_cnt;
    pulse_start();
    check_disp("restart", 1, 2, 1, 1, 1);
    check("restart.nodone", 32'(done_cnt - dc), 32'd0);
    wait_done("restart", n);
    check("restart.len", 32'(n), 32'd120);
    check_disp("restart00", 0, 0, 0, 1, 0);

    // Reset mid-run at 07 s aborts without done
    pulse_start();
    repeat (50) step();
    check_disp("at07", 0, 7, 0, 1, 1);
    dc = done_cnt;
    rst = 1'b1;
    #1;
    check_disp("abort", 10, 11, 1, 1, 0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.fclk", 32'(fast_clk_out), 32'd0);
    step();
    rst = 1'b0;
    step();
    check_disp("abort_idle", 10, 11, 1, 1, 0);
    check("abort.nodone", 32'(done_cnt - dc), 32'd0);
    pulse_start();
    check_disp("rerun", 1, 2, 1, 1, 1);
    wait_done("rerun", n);
    check("rerun.len", 32'(n), 32'd120);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/typing_score_timer.md
TYPING_SCORE_TIMER -- requirements
Module: typing_score_timer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100000000: clk cycles per one second of test time.
REQ-002 Parameter TEST_SECONDS, default 30: test length in seconds, legal range 1..99.
REQ-003 Parameter REFRESH_DIV, default 50000: clk cycles per half-period of fast_clk_out.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  single-cycle pulse; begins or restarts a test.
REQ-007 key_correct  input  1  single-cycle pulse per correctly typed key.
REQ-008 key_wrong  input  1  single-cycle pulse per mistyped key.
REQ-009 digit_one  output  4  left (tens) digit code for the two-digit display driver.
REQ-010 digit_two  output  4  right (units) digit code.
REQ-011 one_en  output  1  left digit enable; 0 blanks it.
REQ-012 two_en  output  1  right digit enable.
REQ-013 fast_clk_out  output  1  square-wave multiplex clock for the display driver.
REQ-014 busy  output  1  high while a test is running.
REQ-015 done  output  1  one-cycle pulse when a test ends.

Function
REQ-016 States SHALL be IDLE, RUN, RESULT; all outputs registered.
REQ-017 IDLE: digit_one=10 ("H"), digit_two=11 ("I"), one_en=two_en=1, busy=0.
REQ-018 start in IDLE or RESULT -> RUN next cycle; score cleared to 00, seconds loaded with TEST_SECONDS (BCD), second-tick counter cleared.
REQ-019 start in RUN restarts the test identically (score 00, seconds reloaded); no done pulse.
REQ-020 RUN: digits show remaining seconds in BCD; one_en=0 when tens digit is 0, else 1; two_en=1; busy=1.
REQ-021 RUN: tick counter counts 0..TICKS_PER_SEC-1 and wraps; at wrap, seconds decrement by 1 in BCD (e.g. 10 -> 09).
REQ-022 Decrement from 01 to 00 -> RESULT next cycle, done=1 for exactly that one cycle, busy=0.
REQ-023 Score is two-digit BCD 00..99: key_correct alone +1 saturating at 99; key_wrong alone -1 saturating at 00; both together or neither: unchanged.
REQ-024 Keys in the same cycle as the final second decrement SHALL be counted; keys in IDLE/RESULT ignored.
REQ-025 RESULT: digits show score; one_en=0 when tens is 0; two_en=1; held until start.
REQ-026 Latency: key pulse at cycle N -> updated digits visible at cycle N+1 in states that show the score; display outputs update within 1 cycle of any state/value change.
REQ-027 fast_clk_out toggles every REFRESH_DIV cycles in all states, free-running, independent of start.
REQ-028 Digit codes 0..9 SHALL be BCD only; codes 12..15 never driven.

Reset
REQ-029 rst asserted: state=IDLE, score=00, seconds=00, tick and refresh counters=0, fast_clk_out=0, busy=0, done=0, digit_one=10, digit_two=11, one_en=two_en=1.
REQ-030 rst mid-RUN SHALL abort the test without a done pulse; operation resumes in IDLE after deassertion.

Structure
REQ-031 Shared package typing_pkg SHALL hold the state enum and digit-code constants (CODE_H=10, CODE_I=11).
REQ-032 Sub-module bcd2_counter (two-digit BCD, load, inc, dec, saturate at 00/99) SHALL be instantiated twice: score and seconds.
REQ-033 Target size 150-300 lines RTL total.

Verification (TICKS_PER_SEC=10, TEST_SECONDS=12, REFRESH_DIV=4)
REQ-034 Reset then idle 20 cycles -> digits 10/11, both enables 1, busy=0, fast_clk_out toggles every 4 cycles.
REQ-035 start, no keys -> seconds 12,11,10,09..01 each 10 cycles, one_en=0 from 09, done pulse once at expiry, RESULT shows 00 with one_en=0.
REQ-036 start, 105 key_correct pulses -> score saturates at 99; then 3 key_wrong -> 96 shown after expiry.
REQ-037 start, 2 key_wrong then 1 key_correct, plus one cycle with both asserted -> score 01.
REQ-038 key_correct in the cycle of the final decrement -> counted in RESULT; start during RUN at 05 s -> seconds reload 12, score 00, no done.
REQ-039 rst pulse at 07 s remaining -> IDLE outputs next cycle, no done pulse, subsequent start runs a full 12 s test.
